// File: rtl/sseg_scan_decoder_if.sv
// Seven-segment scan bus plus decoded result bundle.
// master: drives sseg/an (pins side), reads results.
// slave : the decoder; samples sseg/an, drives results.
//   sseg[6:0]        active-low segments, bit0=a .. bit6=g
//   an[3:0]          active-low anodes, an[i]=0 selects digit i
//   digits[15:0]     recovered nibbles, digit i = digits[4i+3:4i]
//   digit_valid[3:0] nibble i holds a legally decoded value
//   frame_valid      pulse: all 4 digits committed since last pulse
//   err_code         pulse: stable one-hot sample, unknown pattern
//   err_anode        pulse: more than one anode active
interface sseg_scan_decoder_if;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err_code;
    logic        err_anode;

    modport master (
        output sseg, an,
        input  digits, digit_valid, frame_valid,
        input  err_code, err_anode
    );

    modport slave (
        input  sseg, an,
        output digits, digit_valid, frame_valid,
        output err_code, err_anode
    );
endinterface

// File: rtl/sseg_scan_decoder.sv
// Multiplexed 4-digit seven-segment bus monitor: recovers hex digits.
// Ports: clk, rst (sync, active-high), bus (sseg_scan_decoder_if.slave).
// Params: STABLE_CNT samples needed to commit, CNT_W run counter width.
// Option: define SSEG_INPUT_SYNC_EN for a 2-flop input synchronizer.
module sseg_scan_decoder #(
    parameter int STABLE_CNT = 4,
    parameter int CNT_W      = 8
) (
    input logic           clk,
    input logic           rst,
    sseg_scan_decoder_if.slave bus
);
    localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CNT);
    localparam logic [CNT_W-1:0] CMAX   = '1;

    logic [3:0] an_in;
    logic [6:0] sseg_in;

`ifdef SSEG_INPUT_SYNC_EN
    logic [3:0] an_m1, an_m2;
    logic [6:0] sseg_m1, sseg_m2;

    always_ff @(posedge clk) begin
        if (rst) begin
            an_m1   <= 4'hF;
            an_m2   <= 4'hF;
            sseg_m1 <= 7'h7F;
            sseg_m2 <= 7'h7F;
        end else begin
            an_m1   <= bus.an;
            an_m2   <= an_m1;
            sseg_m1 <= bus.sseg;
            sseg_m2 <= sseg_m1;
        end
    end

    assign an_in   = an_m2;
    assign sseg_in = sseg_m2;
`else
    assign an_in   = bus.an;
    assign sseg_in = bus.sseg;
`endif

    logic [3:0]       s_an, p_an;
    logic [6:0]       s_sseg, p_sseg;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       mask;
    logic [15:0]      digits_q;
    logic [3:0]       dv_q;
    logic             fv_q, ec_q, ea_q;

    logic       s_blank, s_onehot, s_multi, p_multi, diff;
    logic       commit, hit;
    logic [1:0] idx;
    logic [3:0] nib, dbit, mask_nxt;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h40:   decode = {1'b1, 4'h0};
            7'h79:   decode = {1'b1, 4'h1};
            7'h24:   decode = {1'b1, 4'h2};
            7'h30:   decode = {1'b1, 4'h3};
            7'h19:   decode = {1'b1, 4'h4};
            7'h12:   decode = {1'b1, 4'h5};
            7'h02:   decode = {1'b1, 4'h6};
            7'h78:   decode = {1'b1, 4'h7};
            7'h00:   decode = {1'b1, 4'h8};
            7'h10:   decode = {1'b1, 4'h9};
            7'h08:   decode = {1'b1, 4'hA};
            7'h03:   decode = {1'b1, 4'hB};
            7'h46:   decode = {1'b1, 4'hC};
            7'h21:   decode = {1'b1, 4'hD};
            7'h06:   decode = {1'b1, 4'hE};
            7'h0E:   decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    assign s_blank  = (s_an == 4'hF);
    assign s_onehot = ($countones(~s_an) == 1);
    assign s_multi  = !s_blank && !s_onehot;
    assign p_multi  = ($countones(~p_an) > 1);
    assign diff     = {s_an, s_sseg} != {p_an, p_sseg};
    assign {hit, nib} = decode(s_sseg);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!s_an[i]) idx = 2'(i);
    end

    always_comb begin
        cnt_nxt = '0;
        if (s_onehot) begin
            if (diff)
                cnt_nxt = CNT_W'(1);
            else if (cnt != CMAX)
                cnt_nxt = cnt + CNT_W'(1);
            else
                cnt_nxt = cnt;
        end
    end

    // Commit only on the step into STABLE, so a run saturating at
    // STABLE cannot commit again on every cycle.
    assign commit   = s_onehot && (cnt_nxt == STABLE)
                   && (diff || (cnt != cnt_nxt));
    assign dbit     = 4'(1) << idx;
    assign mask_nxt = mask | dbit;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_an     <= 4'hF;
            p_an     <= 4'hF;
            s_sseg   <= 7'h7F;
            p_sseg   <= 7'h7F;
            cnt      <= '0;
            mask     <= 4'h0;
            digits_q <= 16'h0;
            dv_q     <= 4'h0;
            fv_q     <= 1'b0;
            ec_q     <= 1'b0;
            ea_q     <= 1'b0;
        end else begin
            s_an   <= an_in;
            s_sseg <= sseg_in;
            p_an   <= s_an;
            p_sseg <= s_sseg;
            cnt    <= cnt_nxt;
            fv_q   <= 1'b0;
            ec_q   <= 1'b0;
            ea_q   <= s_multi && (diff || !p_multi);
            if (commit) begin
                if (hit) begin
                    digits_q[4*idx +: 4] <= nib;
                    dv_q[idx]            <= 1'b1;
                    if (mask_nxt == 4'hF) begin
                        fv_q <= 1'b1;
                        mask <= 4'h0;
                    end else begin
                        mask <= mask_nxt;
                    end
                end else begin
                    dv_q[idx] <= 1'b0;
                    ec_q      <= 1'b1;
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.digit_valid = dv_q;
    assign bus.frame_valid = fv_q;
    assign bus.err_code    = ec_q;
    assign bus.err_anode   = ea_q;
endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Bench for sseg_scan_decoder: sample-history model plus directed
// vectors with literal end-of-phase expectations.
module tb_sseg_scan_decoder;
    localparam int STABLE_CNT = 4;
`ifdef SSEG_INPUT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int H = 6 + SL;
    localparam logic [10:0] IDLE = {4'hF, 7'h7F};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sseg_scan_decoder_if bus ();

    sseg_scan_decoder #(.STABLE_CNT(STABLE_CNT), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Model: history of samples seen by the decoder; decisions use
    // the length of the trailing run of identical samples.
    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                             7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};
    logic [10:0] hist [$];
    logic [10:0] pipe [$];
    logic [15:0] m_dig = 0;
    logic [3:0]  m_dv = 0, m_mask = 0;
    logic        m_fv = 0, m_ec = 0, m_ea = 0;
    bit          started = 0;

    function automatic int run_len();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size()-1]) break;
            n++;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        logic [10:0] s;
        int rl, zeros, d, v;
        started = 1;
        if (rst) begin
            m_dig = 0; m_dv = 0; m_mask = 0;
            m_fv = 0; m_ec = 0; m_ea = 0;
            hist.delete(); hist.push_back(IDLE);
            pipe.delete(); pipe.push_back(IDLE); pipe.push_back(IDLE);
        end else begin
            s = hist[hist.size()-1];
            rl = run_len();
            zeros = 0; d = 0;
            for (int i = 0; i < 4; i++)
                if (!s[7+i]) begin zeros++; d = i; end
            m_fv = 0; m_ec = 0; m_ea = 0;
            if (zeros >= 2 && rl == 1) m_ea = 1;
            if (zeros == 1 && rl == STABLE_CNT) begin
                v = -1;
                for (int k = 0; k < 16; k++)
                    if (tbl[k] == s[6:0]) v = k;
                if (v >= 0) begin
                    m_dig[4*d +: 4] = 4'(v);
                    m_dv[d] = 1;
                    m_mask[d] = 1;
                    if (m_mask == 4'hF) begin
                        m_fv = 1; m_mask = 0;
                    end
                end else begin
                    m_dv[d] = 0;
                    m_ec = 1;
                end
            end
            if (SL > 0) begin
                pipe.push_back({bus.an, bus.sseg});
                hist.push_back(pipe.pop_front());
            end else begin
                hist.push_back({bus.an, bus.sseg});
            end
            if (hist.size() > 600) void'(hist.pop_front());
        end
    end

    int c_fv = 0, c_ec = 0, c_ea = 0;

    always @(negedge clk) begin
        if (started) begin
            check("digits", 32'(bus.digits), 32'(m_dig));
            check("digit_valid", 32'(bus.digit_valid), 32'(m_dv));
            check("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
            check("err_code", 32'(bus.err_code), 32'(m_ec));
            check("err_anode", 32'(bus.err_anode), 32'(m_ea));
            c_fv += int'(bus.frame_valid);
            c_ec += int'(bus.err_code);
            c_ea += int'(bus.err_anode);
        end
    end

    task automatic drive(input logic [3:0] a, input logic [6:0] s,
                         input int n);
        bus.an   = a;
        bus.sseg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    int b_fv, b_ec, b_ea;

    initial begin
        bus.an = 4'hF;
        bus.sseg = 7'h7F;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        drive(4'hF, 7'h7F, 20);
        check("idle_digits", 32'(bus.digits), 32'h0);
        check("idle_valid", 32'(bus.digit_valid), 32'h0);
        check("idle_pulses", 32'(c_fv + c_ec + c_ea), 32'h0);

        b_fv = c_fv;
        drive(4'hE, 7'h30, H);
        drive(4'hD, 7'h79, H);
        drive(4'hB, 7'h24, H);
        drive(4'h7, 7'h00, H);
        drive(4'hF, 7'h7F, 2);
        check("frame_digits", 32'(bus.digits), 32'h8213);
        check("frame_valid_mask", 32'(bus.digit_valid), 32'hF);
        check("frame_pulses", 32'(c_fv - b_fv), 32'd1);

        drive(4'hE, 7'h40, 3);
        drive(4'hE, 7'h12, 4 + SL);
        drive(4'hF, 7'h7F, 3);
        check("ghost_digits", 32'(bus.digits), 32'h8215);

        b_ec = c_ec;
        drive(4'hB, 7'h7F, 4 + SL);
        drive(4'hF, 7'h7F, 3);
        check("illegal_pulses", 32'(c_ec - b_ec), 32'd1);
        check("illegal_valid", 32'(bus.digit_valid), 32'hB);
        check("illegal_digit2", 32'(bus.digits[11:8]), 32'h2);

        b_ea = c_ea;
        drive(4'hC, 7'h00, 10);
        check("anode_pulses", 32'(c_ea - b_ea), 32'd1);
        check("anode_digits", 32'(bus.digits), 32'h8215);
        check("anode_valid", 32'(bus.digit_valid), 32'hB);
        drive(4'hD, 7'h24, H);
        check("restart_digits", 32'(bus.digits), 32'h8225);
        drive(4'hF, 7'h7F, 2);

        b_fv = c_fv;
        drive(4'hE, 7'h19, 2);
        rst = 1'b1;
        drive(4'hE, 7'h19, 1);
        rst = 1'b0;
        drive(4'hE, 7'h19, 3);
        check("midrst_digits", 32'(bus.digits), 32'h0);
        check("midrst_valid", 32'(bus.digit_valid), 32'h0);
        drive(4'hE, 7'h19, 300);
        check("sat_digits", 32'(bus.digits), 32'h0004);
        check("sat_valid", 32'(bus.digit_valid), 32'h1);
        check("sat_frames", 32'(c_fv - b_fv), 32'd0);
        drive(4'hF, 7'h7F, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Receive side of the multiplexed 4-digit seven-segment bus: samples the segment bus `sseg` and the anode bus `an`, and recovers the hex nibble shown on each digit.
- Exact inverse of the BCD/hex-to-segment decoder plus anode scanner. Used as an on-chip checker/monitor and in loopback of the display path.
- Rejects scan ghosting with a stability filter and flags illegal patterns and illegal anode states.

Parameters:
- STABLE_CNT, 4: consecutive identical samples required before a digit is committed. Legal range 1 .. 2^CNT_W-1.
- CNT_W, 8: width of the run-length counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- sseg  in  7  segment bus, active-low; bit0=a .. bit6=g
- an  in  4  anode bus, active-low; an[i]=0 selects digit i
- digits  out  16  recovered nibbles; digit i = digits[4i+3:4i]
- digit_valid  out  4  bit i=1: digits nibble i holds a legally decoded value
- frame_valid  out  1  one-cycle pulse: all 4 digits committed since the previous pulse
- err_code  out  1  one-cycle pulse: a stable, one-hot-anode sample had an unknown segment pattern
- err_anode  out  1  one-cycle pulse: a sample had more than one anode active

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - digits=0, digit_valid=0, frame_valid=0, err_code=0, err_anode=0.
  - Run counter=0, committed mask=0, input/previous-sample registers cleared to {an=4'hF, sseg=7'h7F}.
  - A run in progress is discarded; after reset deassertion a full STABLE_CNT run is required before any commit.
- Input stage: `an`/`sseg` registered once (sample S). The previous sample P is also held.
- Anode classification of S:
  - blank (an=4'hF): counter<=0; no commit, no error.
  - one-hot (exactly one zero): counter<=1 if S!=P, else saturating counter+1.
  - multi (two or more zeros): counter<=0. err_anode pulses once on the first multi sample of a run (S!=P or P not multi); a repeated identical multi sample does not re-pulse.
- Commit: occurs when a one-hot run length becomes exactly STABLE_CNT. Each run commits once; holding the same sample longer produces no further commits.
- Decode table (active-low hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - Match: digits[i]<=nibble, digit_valid[i]<=1, mask[i]<=1.
  - No match: digit_valid[i]<=0, digits[i] unchanged, err_code pulses, mask unchanged.
- Frame: if a valid commit makes mask==4'hF, frame_valid pulses on the same edge as that commit's outputs and mask<=0 on that edge. Re-committing a digit already in the mask updates its value but does not pulse frame_valid.
- Latency without sync: a pair stable on the pins from cycle t is reflected in the outputs after the clk edge at t+STABLE_CNT. STABLE_CNT=1 therefore commits one edge after the first sample.
- Simultaneous events: at most one of err_code, err_anode and a commit can occur per cycle, since they are mutually exclusive by anode class.
- Counter saturates at 2^CNT_W-1 and never wraps, so there is no spurious re-commit.

Optional Feature:
- Macro: SSEG_INPUT_SYNC_EN.
- Defined: a 2-flop synchronizer on `an` and `sseg` ahead of the input stage, for pins driven from another clock domain or from an external board. All latencies grow by +2 cycles; reset clears the synchronizer flops to {4'hF, 7'h7F}.
- Undefined: inputs are treated as synchronous to clk; latency is as stated in Behaviour.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, drive an=F, sseg=7F for 20 cycles -> all outputs 0, no pulses.
- Full frame, STABLE_CNT=4: drive each (an, sseg) pair for 6 cycles in order (E,30), (D,79), (B,24), (7,00) -> digits=16'h8213, digit_valid=F, a single frame_valid pulse coincident with the digit-3 commit.
- Ghost rejection: (E,40) held 3 cycles, then (E,12) held 4 cycles -> digits[3:0]=5 only; value 0 is never committed.
- Illegal pattern: (B,7F) held 4 cycles after digit 2 was valid -> err_code pulses once, digit_valid[2]=0, digits[11:8] unchanged.
- Illegal anode: an=C (two digits active), sseg=00 held 10 cycles -> err_anode pulses exactly once; no commit; counter restarts on the next one-hot sample.
- Reset mid-run and saturation: (E,19) for 2 cycles, rst for 1 cycle, (E,19) for 3 more cycles -> no commit. Continue holding 300 cycles with CNT_W=8 -> exactly one commit (digit 0 = 4), no repeat.
